data_mem_bank: RTL

- Parametrised successor to the single-port data memory used by the MEM stage.
- Adds byte-lane write enables and a valid/ready request interface.
- Read data is registered with a one-cycle response, and out-of-range accesses are detected.
- After reset, a hardware clear sequencer zeroes the array before accepting requests, so the pipeline never reads uninitialised data.

---
 rtl/data_mem_bank_if.sv | 27 ++
 rtl/data_mem_bank.sv | 111 +++++++++++
 2 files changed

// File: rtl/data_mem_bank_if.sv
// Request/response bus for data_mem_bank: valid/ready request in,
// single-cycle response pulse out, plus the init status flag.
interface data_mem_bank_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;
  logic                    init_busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );
endinterface

// File: rtl/data_mem_bank.sv
// Single-port data memory bank with byte-lane writes, valid/ready requests,
// registered one-cycle responses, out-of-range detection and a post-reset
// clear sequencer that zeroes the array before any request is accepted.
module data_mem_bank #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 11,
  parameter int MEMORY_DEPTH   = 2048,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_bank_if.slave bus
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int IDX_W     = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  // One extra bit so a depth of exactly 2**ADDR_WIDTH is representable and
  // the range check never flags an address.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(MEMORY_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic [DATA_WIDTH-1:0]   mem [MEMORY_DEPTH];

  logic                    accept;
  logic                    in_range;
  logic                    wr_en;
  logic [IDX_W-1:0]        req_idx;
  logic [IDX_W-1:0]        clr_idx;

  assign accept   = bus.req_valid && ready_q;
  assign in_range = {1'b0, bus.req_addr} < DEPTH_EXT;
  assign wr_en    = accept && bus.req_we && in_range;
  assign req_idx  = bus.req_addr[IDX_W-1:0];
  assign clr_idx  = clr_ptr_q[IDX_W-1:0];

  // Clear sequencer: walk the array once, then park in IDLE until reset.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == ST_CLEAR) begin
      if (clr_ptr_q == LAST_ADDR) begin
        state_d = ST_IDLE;
      end else begin
        clr_ptr_d = clr_ptr_q + 1'b1;
      end
    end
    ready_d = (state_d == ST_IDLE);
    busy_d  = !ready_d;
  end

  // Response: read-first data for in-range reads, zero otherwise; data and
  // err hold between pulses.
  always_comb begin
    rsp_valid_d = accept;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_err_d   = !in_range;
      rsp_rdata_d = (!bus.req_we && in_range) ? mem[req_idx] : '0;
    end
  end

  // Control and response registers; reset also squashes any pending response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_ptr_q   <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array writes: clear zeroes one word per cycle; requests update enabled lanes.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == ST_CLEAR) begin
        mem[clr_idx] <= '0;
      end else if (wr_en) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (bus.req_be[i]) mem[req_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.init_busy = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
